// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: groups the two requester channels (A = instruction
// fetch, B = data/stack load) and the shared ROM read port of the arbiter.
// The arbiter takes the slave view; the CPU side and ROM take the master view.
interface mem_port_arbiter_if #(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4
);
    // Response width: one byte per extra-byte selector value.
    localparam int DW = (2 ** MEM_EXTRA) * 8;

    // Requester A: instruction fetch
    logic                 a_req;
    logic [MEM_ADDR:0]    a_addr;
    logic [MEM_EXTRA-1:0] a_extra;
    logic                 a_ready;
    logic                 a_valid;
    logic [DW-1:0]        a_data;
    logic                 a_error;

    // Requester B: data/stack load with an access window and beat lock
    logic                 b_req;
    logic                 b_lock;
    logic [MEM_ADDR:0]    b_addr;
    logic [MEM_EXTRA-1:0] b_extra;
    logic [MEM_ADDR:0]    b_lower_bound;
    logic [MEM_ADDR:0]    b_upper_bound;
    logic                 b_ready;
    logic                 b_valid;
    logic [DW-1:0]        b_data;
    logic                 b_error;

    // Shared ROM read port
    logic [MEM_ADDR:0]    mem_addr;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [MEM_ADDR:0]    mem_lower_bound;
    logic [MEM_ADDR:0]    mem_upper_bound;
    logic [DW-1:0]        mem_data;
    logic                 mem_error;

    modport slave (
        input  a_req, a_addr, a_extra,
        output a_ready, a_valid, a_data, a_error,
        input  b_req, b_lock, b_addr, b_extra, b_lower_bound, b_upper_bound,
        output b_ready, b_valid, b_data, b_error,
        output mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
        input  mem_data, mem_error
    );

    modport master (
        output a_req, a_addr, a_extra,
        input  a_ready, a_valid, a_data, a_error,
        output b_req, b_lock, b_addr, b_extra, b_lower_bound, b_upper_bound,
        input  b_ready, b_valid, b_data, b_error,
        input  mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
        output mem_data, mem_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single ROM read port between instruction fetch
// (A) and data/stack load (B). Round-robin between the two, with a bounded
// lock so a multi-beat B access can keep the port for up to MAX_LOCK grants
// while A is waiting. The ROM answers one cycle after the address register is
// loaded, so a one-entry tag {pending, owner} routes each response back.
module mem_port_arbiter #(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4,
    parameter int MAX_LOCK  = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    // Lock counter must be able to hold MAX_LOCK itself.
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LOCK_MAX_C  = LW'(MAX_LOCK);
    localparam logic [LW-1:0] LOCK_ZERO_C = {LW{1'b0}};
    localparam logic [LW-1:0] LOCK_ONE_C  = LW'(1);

    localparam logic [MEM_ADDR:0]    ADDR_ZERO_C  = {(MEM_ADDR + 1){1'b0}};
    localparam logic [MEM_ADDR:0]    ADDR_ONES_C  = {(MEM_ADDR + 1){1'b1}};
    localparam logic [MEM_EXTRA-1:0] EXTRA_ZERO_C = {MEM_EXTRA{1'b0}};

    // In-flight tag encoding: {pending, owner}; owner 0 = A, 1 = B.
    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_A    = 2'b10;
    localparam logic [1:0] TAG_B    = 2'b11;

    // Arbitration state
    logic            last_b_r;       // 1: most recent grant went to B
    logic            prev_b_lock_r;  // most recent grant was B with b_lock set
    logic [LW-1:0]   lock_cnt_r;     // locked B grants taken while A waited
    logic [1:0]      tag_r;          // owner of the read now returning

    // ROM-facing address/bounds registers
    logic [MEM_ADDR:0]    mem_addr_r;
    logic [MEM_EXTRA-1:0] mem_extra_r;
    logic [MEM_ADDR:0]    mem_lower_r;
    logic [MEM_ADDR:0]    mem_upper_r;

    // Combinational decisions
    logic grant_a_s;
    logic grant_b_s;
    logic lock_active_s;
    logic a_valid_s;
    logic b_valid_s;

    // Grant selection: single requester wins outright; contention goes to the
    // side not served last unless B still holds an unexpired lock.
    always_comb begin
        grant_a_s     = 1'b0;
        grant_b_s     = 1'b0;
        lock_active_s = prev_b_lock_r & (lock_cnt_r < LOCK_MAX_C);
        if (reset) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
            case ({bus.a_req, bus.b_req})
                2'b10: grant_a_s = 1'b1;
                2'b01: grant_b_s = 1'b1;
                2'b11: begin
                    if (lock_active_s || !last_b_r) begin
                        grant_b_s = 1'b1;
                    end else begin
                        grant_a_s = 1'b1;
                    end
                end
                default: begin
                    grant_a_s = 1'b0;
                    grant_b_s = 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer and lock bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b_r      <= 1'b1;
            prev_b_lock_r <= 1'b0;
            lock_cnt_r    <= LOCK_ZERO_C;
        end else begin
            if (grant_a_s || grant_b_s) begin
                last_b_r      <= grant_b_s;
                prev_b_lock_r <= grant_b_s & bus.b_lock;
            end
            // A grant or a released lock ends the streak; otherwise each
            // locked B grant that made A wait uses up one slot.
            if (grant_a_s || !bus.b_lock) begin
                lock_cnt_r <= LOCK_ZERO_C;
            end else if (grant_b_s && bus.a_req && (lock_cnt_r < LOCK_MAX_C)) begin
                lock_cnt_r <= lock_cnt_r + LOCK_ONE_C;
            end
        end
    end

    // Load the winner's address, extra count and access window for the ROM;
    // A always reads with the full window, B with its own bounds.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_r  <= ADDR_ZERO_C;
            mem_extra_r <= EXTRA_ZERO_C;
            mem_lower_r <= ADDR_ZERO_C;
            mem_upper_r <= ADDR_ONES_C;
        end else if (grant_a_s) begin
            mem_addr_r  <= bus.a_addr;
            mem_extra_r <= bus.a_extra;
            mem_lower_r <= ADDR_ZERO_C;
            mem_upper_r <= ADDR_ONES_C;
        end else if (grant_b_s) begin
            mem_addr_r  <= bus.b_addr;
            mem_extra_r <= bus.b_extra;
            mem_lower_r <= bus.b_lower_bound;
            mem_upper_r <= bus.b_upper_bound;
        end
    end

    // Record who owns the read issued this cycle; a new grant may overwrite
    // the tag in the same cycle the previous response is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_r <= TAG_NONE;
        end else if (grant_a_s) begin
            tag_r <= TAG_A;
        end else if (grant_b_s) begin
            tag_r <= TAG_B;
        end else begin
            tag_r <= TAG_NONE;
        end
    end

    // Decode the tag into per-requester valids; nothing is delivered while
    // reset is held, even if the ROM is still answering an older read.
    always_comb begin
        a_valid_s = 1'b0;
        b_valid_s = 1'b0;
        if (reset) begin
            a_valid_s = 1'b0;
            b_valid_s = 1'b0;
        end else begin
            case (tag_r)
                TAG_A:   a_valid_s = 1'b1;
                TAG_B:   b_valid_s = 1'b1;
                default: begin
                    a_valid_s = 1'b0;
                    b_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.a_ready = grant_a_s;
    assign bus.b_ready = grant_b_s;

    assign bus.mem_addr        = mem_addr_r;
    assign bus.mem_extra       = mem_extra_r;
    assign bus.mem_lower_bound = mem_lower_r;
    assign bus.mem_upper_bound = mem_upper_r;

    // ROM data is broadcast; the valid strobe tells each side when it is theirs.
    assign bus.a_valid = a_valid_s;
    assign bus.b_valid = b_valid_s;
    assign bus.a_data  = bus.mem_data;
    assign bus.b_data  = bus.mem_data;
    assign bus.a_error = bus.mem_error & a_valid_s;
    assign bus.b_error = bus.mem_error & b_valid_s;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven vectors, hand sequences for the
// multi-cycle corners, and random traffic checked against a transaction-level
// model (grant rule plus a queue of expected responses).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int MEM_ADDR  = 4;
    localparam int MEM_EXTRA = 4;
    localparam int MAX_LOCK  = 2;
    localparam int DW        = (2 ** MEM_EXTRA) * 8;
    localparam int AW        = MEM_ADDR + 1;
    localparam logic [AW-1:0] ALL1 = {AW{1'b1}};

    logic clk = 1'b0;
    logic reset;

    mem_port_arbiter_if #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) bus();

    mem_port_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA), .MAX_LOCK(MAX_LOCK)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: each byte is a simple function of address, lane and extra.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] addr, input logic [MEM_EXTRA-1:0] ext);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW / 8; i++) w[i*8 +: 8] = 8'(int'(addr) * 17 + i * 3 + int'(ext));
        return w;
    endfunction

    function automatic logic rom_err(input logic [AW-1:0] addr, input logic [MEM_EXTRA-1:0] ext,
                                     input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        return (addr < lo) || (int'(addr) + int'(ext) > int'(hi));
    endfunction

    // Combinational ROM behind the registered address: data appears the cycle after grant.
    always_comb begin
        bus.mem_data  = rom_word(bus.mem_addr, bus.mem_extra);
        bus.mem_error = rom_err(bus.mem_addr, bus.mem_extra, bus.mem_lower_bound, bus.mem_upper_bound);
    end

    // ---------------- reference model ----------------
    typedef struct { bit owner_b; logic [DW-1:0] data; bit err; } resp_t;
    resp_t resp_q[$];
    bit    m_last_b;    // last winner was B
    bit    m_prev_lock; // last winner was B asking to keep the port
    int    m_streak;    // locked B grants taken while A waited
    logic [AW-1:0] m_addr, m_lo, m_hi;
    logic [MEM_EXTRA-1:0] m_extra;

    int n_cmp = 0;
    int n_bad = 0;
    int g_cur;                // model grant of the last tick: 0 none, 1 A, 2 B
    logic smp_ar, smp_br, smp_av, smp_bv, smp_ae, smp_be;
    logic [DW-1:0] smp_ad, smp_bd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        resp_q.delete();
        m_last_b = 1'b1; m_prev_lock = 1'b0; m_streak = 0;
        m_addr = '0; m_extra = '0; m_lo = '0; m_hi = ALL1;
    endfunction

    function automatic int model_grant();
        if (reset) return 0;
        if (bus.a_req && !bus.b_req) return 1;
        if (bus.b_req && !bus.a_req) return 2;
        if (!bus.a_req && !bus.b_req) return 0;
        if (m_prev_lock && m_streak < MAX_LOCK) return 2;
        return m_last_b ? 1 : 2;
    endfunction

    // One clock: compare DUT against model mid-cycle, then advance the model.
    task automatic tick();
        bit ev_a, ev_b, e_err;
        logic [DW-1:0] e_data;
        @(negedge clk);
        g_cur = model_grant();
        ev_a = 1'b0; ev_b = 1'b0; e_err = 1'b0; e_data = '0;
        if (!reset && resp_q.size() > 0) begin
            ev_a = !resp_q[0].owner_b; ev_b = resp_q[0].owner_b;
            e_err = resp_q[0].err; e_data = resp_q[0].data;
        end
        smp_ar = bus.a_ready; smp_br = bus.b_ready; smp_av = bus.a_valid; smp_bv = bus.b_valid;
        smp_ae = bus.a_error; smp_be = bus.b_error; smp_ad = bus.a_data; smp_bd = bus.b_data;
        chk("a_ready", smp_ar, DW'(g_cur == 1));
        chk("b_ready", smp_br, DW'(g_cur == 2));
        chk("a_valid", smp_av, DW'(ev_a));
        chk("b_valid", smp_bv, DW'(ev_b));
        chk("a_error", smp_ae, DW'(ev_a & e_err));
        chk("b_error", smp_be, DW'(ev_b & e_err));
        if (ev_a) chk("a_data", smp_ad, e_data);
        if (ev_b) chk("b_data", smp_bd, e_data);
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_extra", bus.mem_extra, m_extra);
        chk("mem_lower_bound", bus.mem_lower_bound, m_lo);
        chk("mem_upper_bound", bus.mem_upper_bound, m_hi);
        @(posedge clk);
        resp_q.delete();
        if (reset) begin
            model_reset();
        end else begin
            if (g_cur == 1) begin
                resp_q.push_back('{1'b0, rom_word(bus.a_addr, bus.a_extra), rom_err(bus.a_addr, bus.a_extra, '0, ALL1)});
                m_addr = bus.a_addr; m_extra = bus.a_extra; m_lo = '0; m_hi = ALL1;
            end else if (g_cur == 2) begin
                resp_q.push_back('{1'b1, rom_word(bus.b_addr, bus.b_extra),
                                   rom_err(bus.b_addr, bus.b_extra, bus.b_lower_bound, bus.b_upper_bound)});
                m_addr = bus.b_addr; m_extra = bus.b_extra; m_lo = bus.b_lower_bound; m_hi = bus.b_upper_bound;
            end
            if (g_cur != 0) begin
                m_last_b = (g_cur == 2);
                m_prev_lock = (g_cur == 2) && bus.b_lock;
            end
            if (g_cur == 1 || !bus.b_lock) m_streak = 0;
            else if (g_cur == 2 && bus.a_req) m_streak++;
        end
        #1;
    endtask

    task automatic idle();
        bus.a_req = 1'b0; bus.b_req = 1'b0; bus.b_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; tick(); reset = 1'b0;
    endtask

    typedef struct {
        bit ar; logic [AW-1:0] aa; logic [MEM_EXTRA-1:0] ae;
        bit br; bit bl; logic [AW-1:0] ba; logic [MEM_EXTRA-1:0] be;
        logic [AW-1:0] lo; logic [AW-1:0] hi;
        bit exp_ar; bit exp_br;
    } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 5'd3,  4'd0, 1'b0, 1'b0, 5'd0,  4'd0, 5'd0, 5'd31, 1'b1, 1'b0}; // single A
        vt[1] = '{1'b0, 5'd0,  4'd0, 1'b0, 1'b0, 5'd0,  4'd0, 5'd0, 5'd31, 1'b0, 1'b0}; // idle
        vt[2] = '{1'b1, 5'd4,  4'd1, 1'b1, 1'b0, 5'd5,  4'd2, 5'd0, 5'd31, 1'b0, 1'b1}; // contention
        vt[3] = '{1'b1, 5'd6,  4'd1, 1'b1, 1'b0, 5'd7,  4'd2, 5'd0, 5'd31, 1'b1, 1'b0};
        vt[4] = '{1'b1, 5'd8,  4'd1, 1'b1, 1'b0, 5'd9,  4'd2, 5'd0, 5'd31, 1'b0, 1'b1};
        vt[5] = '{1'b1, 5'd10, 4'd1, 1'b1, 1'b0, 5'd11, 4'd2, 5'd0, 5'd31, 1'b1, 1'b0};
        vt[6] = '{1'b0, 5'd0,  4'd0, 1'b1, 1'b0, 5'd20, 4'd3, 5'd18, 5'd25, 1'b0, 1'b1}; // B only
        vt[7] = '{1'b1, 5'd28, 4'd7, 1'b1, 1'b0, 5'd1,  4'd0, 5'd0, 5'd31, 1'b1, 1'b0}; // A after B, A errs

        idle();
        bus.a_addr = '0; bus.a_extra = '0; bus.b_addr = '0; bus.b_extra = '0;
        bus.b_lower_bound = '0; bus.b_upper_bound = ALL1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state while reset is still high
        chk("rst_a_ready", bus.a_ready, '0);
        chk("rst_a_valid", bus.a_valid, '0);
        chk("rst_b_valid", bus.b_valid, '0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_upper", bus.mem_upper_bound, DW'(ALL1));
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        #1;
        chk("rst_ready_gated", {bus.a_ready, bus.b_ready}, '0);
        idle();
        model_reset();
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            bus.a_req = vt[i].ar; bus.a_addr = vt[i].aa; bus.a_extra = vt[i].ae;
            bus.b_req = vt[i].br; bus.b_lock = vt[i].bl; bus.b_addr = vt[i].ba; bus.b_extra = vt[i].be;
            bus.b_lower_bound = vt[i].lo; bus.b_upper_bound = vt[i].hi;
            tick();
            chk($sformatf("vec%0d_a_ready", i), smp_ar, DW'(vt[i].exp_ar));
            chk($sformatf("vec%0d_b_ready", i), smp_br, DW'(vt[i].exp_br));
        end
        idle(); tick();

        // Bounds error: B addr 8, window 0..4
        bus.b_req = 1'b1; bus.b_addr = 5'd8; bus.b_extra = 4'd0;
        bus.b_lower_bound = 5'd0; bus.b_upper_bound = 5'd4;
        tick();
        chk("bnd_mem_lower", bus.mem_lower_bound, DW'(5'd0));
        chk("bnd_mem_upper", bus.mem_upper_bound, DW'(5'd4));
        idle(); tick();
        chk("bnd_b_error", smp_be, DW'(1'b1));
        chk("bnd_a_error", smp_ae, DW'(1'b0));

        // Lock bound: expected grant order A,B,B,A,B,B,A
        do_reset();
        bus.a_req = 1'b1; bus.b_req = 1'b1; bus.b_lock = 1'b1;
        bus.a_addr = 5'd2; bus.b_addr = 5'd3; bus.b_lower_bound = '0; bus.b_upper_bound = ALL1;
        for (int i = 0; i < 7; i++) begin
            logic exp_b;
            exp_b = (i % 3) != 0;
            tick();
            chk($sformatf("lock%0d_b_ready", i), smp_br, DW'(exp_b));
            chk($sformatf("lock%0d_a_ready", i), smp_ar, DW'(!exp_b));
        end
        idle(); tick();

        // Reset mid-flight
        bus.a_req = 1'b1; bus.a_addr = 5'd6; bus.a_extra = 4'd1;
        tick();
        idle(); reset = 1'b1;
        tick();
        chk("rmf_a_valid", smp_av, DW'(1'b0));
        reset = 1'b0;
        chk("rmf_mem_addr", bus.mem_addr, '0);
        chk("rmf_mem_extra", bus.mem_extra, '0);
        chk("rmf_mem_lower", bus.mem_lower_bound, '0);
        chk("rmf_mem_upper", bus.mem_upper_bound, DW'(ALL1));
        bus.a_req = 1'b1; bus.b_req = 1'b1; bus.a_addr = 5'd1; bus.b_addr = 5'd2;
        tick();
        chk("rmf_first_grant_a", smp_ar, DW'(1'b1));
        idle(); tick();

        // Back-to-back A at 0,1,2
        bus.a_extra = 4'd0;
        for (int i = 0; i < 4; i++) begin
            bus.a_req = (i < 3); bus.a_addr = AW'(i);
            tick();
            if (i > 0) begin
                chk($sformatf("b2b%0d_a_valid", i), smp_av, DW'(1'b1));
                chk($sformatf("b2b%0d_a_data", i), smp_ad, rom_word(AW'(i - 1), 4'd0));
            end
        end
        idle(); tick();

        // Random traffic; a requester holds its request until granted (mostly)
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(63) == 0);
            if (!(bus.a_req && g_cur != 1 && $urandom_range(9) != 0)) begin
                bus.a_req = 1'($urandom_range(1)); bus.a_addr = AW'($urandom); bus.a_extra = MEM_EXTRA'($urandom);
            end
            if (!(bus.b_req && g_cur != 2 && $urandom_range(9) != 0)) begin
                bus.b_req = 1'($urandom_range(1)); bus.b_addr = AW'($urandom); bus.b_extra = MEM_EXTRA'($urandom);
                bus.b_lower_bound = AW'($urandom_range(15)); bus.b_upper_bound = AW'($urandom_range(31, 10));
            end
            bus.b_lock = ($urandom_range(9) < 6);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single genrom read port between two CPU-side requesters: A = instruction fetch, B = data/stack load.
- Sits between the cpu core and the ROM.
- Drives mem_addr, mem_extra and the bounds, and routes mem_data/mem_error back to the requester that owns each in-flight read.
- Round-robin arbitration, plus a bounded lock for multi-beat B accesses (e.g. an i64 spanning two reads).

Parameters:
- MEM_ADDR, 4: address MSB index; address ports are MEM_ADDR+1 bits.
- MEM_EXTRA, 4: extra-byte selector width; data width DW = 2**MEM_EXTRA*8 (localparam).
- MAX_LOCK, 4: maximum consecutive B grants under lock while A is requesting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_req  in  1  A read request
- a_addr  in  MEM_ADDR+1  A address
- a_extra  in  MEM_EXTRA  A extra-byte count
- a_ready  out  1  A request accepted this cycle
- a_valid  out  1  A response valid
- a_data  out  DW  A response data
- a_error  out  1  A response bounds error
- b_req  in  1  B read request
- b_lock  in  1  B holds priority for its next beat
- b_addr  in  MEM_ADDR+1  B address
- b_extra  in  MEM_EXTRA  B extra-byte count
- b_lower_bound  in  MEM_ADDR+1  B access window, low
- b_upper_bound  in  MEM_ADDR+1  B access window, high
- b_ready  out  1  B request accepted this cycle
- b_valid  out  1  B response valid
- b_data  out  DW  B response data
- b_error  out  1  B response bounds error
- mem_addr  out  MEM_ADDR+1  to ROM
- mem_extra  out  MEM_EXTRA  to ROM
- mem_lower_bound  out  MEM_ADDR+1  to ROM
- mem_upper_bound  out  MEM_ADDR+1  to ROM
- mem_data  in  DW  from ROM, valid 1 cycle after address
- mem_error  in  1  from ROM, valid 1 cycle after address

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: a_valid=b_valid=0, mem_addr=0, mem_extra=0, mem_lower_bound=0, mem_upper_bound=all-ones. Round-robin pointer last=B (so A wins first), lock_cnt=0, in-flight tag cleared.
- While reset is high: a_ready=b_ready=0.
- Grant (combinational, one per cycle):
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant the one not granted last, unless lock is active.
- Lock:
  - lock is active when the previous grant was B with b_lock=1 and lock_cnt<MAX_LOCK.
  - lock_cnt increments on each locked B grant while a_req=1, and clears on any A grant or when b_lock=0.
  - At lock_cnt==MAX_LOCK, A wins the next contested cycle.
- Readiness: a_ready / b_ready = the grant for that requester.
- Address register:
  - On grant, register the winner's addr/extra into mem_addr/mem_extra.
  - Bounds: A gets 0 and all-ones. B gets b_lower_bound / b_upper_bound.
  - With no grant, the mem_* outputs hold their previous values.
- Tag pipeline:
  - Register tag = {pending, owner} on grant.
  - Next cycle, if pending: assert owner's valid for exactly 1 cycle. owner's data/error = mem_data/mem_error.
  - Full throughput: a new grant is allowed in the same cycle a response returns (back-to-back).
- Data outputs: a_data and b_data are mem_data unconditionally; valid qualifies them. a_error = mem_error & a_valid; likewise for B.
- Held requests: a requester keeps req asserted until it sees ready. A req dropped before grant is simply not served.
- Reset mid-operation: the in-flight tag is cleared, so no valid pulse follows reset, even if the ROM returns data.
- Errors: mem_error is passed through, not interpreted. There are no internal traps.

Test Plan:
- Single A: a_req=1, a_addr=3, 1 cycle -> a_ready=1 same cycle; next cycle a_valid=1, a_data=ROM[3..], b_valid=0.
- Contention: both req held 4 cycles, no lock -> grants A,B,A,B; valids alternate, each 1 cycle after its grant.
- Lock bound: MAX_LOCK=2, b_lock=1, both req held -> grants B,B,A (after the initial A), then lock_cnt=0.
- Bounds error: B addr=8, bounds 0..4 -> mem_lower/upper_bound=0/4; next cycle b_error=1, a_error=0.
- Reset mid-flight: grant A, assert reset next cycle -> a_valid stays 0, all outputs at reset values, first post-reset contested grant goes to A.
- Back-to-back A at addr 0,1,2 -> a_valid high 3 consecutive cycles, correct data each cycle.
